sdram_arbiter: RTL and testbench

Schedules the single shared SDRAM port between the four NeoGeo requesters: CD/DMA writes, C ROM sprite bursts, S ROM fix reads and 68k/DMA reads. It sits between the request-strobe sources (PCK1/PCK2, 68k/DMA strobes) and the SDRAM controller. It owns request capture, priority selection, a starvation guard and the issue/complete handshake. Its one-hot grant drives the downstream address/data mux and read-data latches.

---
 rtl/sdram_arb_pkg.sv | 41 ++++
 rtl/sdram_arb_edge.sv | 21 ++
 rtl/sdram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sdram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the NeoGeo SDRAM port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone
    } arb_state_e;

    localparam int unsigned REQ_CDWR = 0;
    localparam int unsigned REQ_CROM = 1;
    localparam int unsigned REQ_SROM = 2;
    localparam int unsigned REQ_M68K = 3;

    localparam int unsigned AGE_W = 8;
    localparam int unsigned TMO_W = 8;

    // One-hot winner; a starving M68K request beats either fixed order.
    function automatic logic [3:0] prio_select(input logic [3:0] pend,
                                               input logic       dma,
                                               input logic       starve);
        logic [3:0] sel;
        sel = 4'b0000;
        if (starve && pend[REQ_M68K]) begin
            sel[REQ_M68K] = 1'b1;
        end else if (dma) begin
            if (pend[REQ_CROM])      sel[REQ_CROM] = 1'b1;
            else if (pend[REQ_SROM]) sel[REQ_SROM] = 1'b1;
            else if (pend[REQ_CDWR]) sel[REQ_CDWR] = 1'b1;
            else if (pend[REQ_M68K]) sel[REQ_M68K] = 1'b1;
        end else begin
            if (pend[REQ_CDWR])      sel[REQ_CDWR] = 1'b1;
            else if (pend[REQ_CROM]) sel[REQ_CROM] = 1'b1;
            else if (pend[REQ_SROM]) sel[REQ_SROM] = 1'b1;
            else if (pend[REQ_M68K]) sel[REQ_M68K] = 1'b1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sdram_arb_edge.sv
// Two-flop rising-edge detector for one request strobe.
module sdram_arb_edge (
    input  logic clk_sys,
    input  logic RESET,
    input  logic sig,
    output logic rise
);

    logic [1:0] sr_q;

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            sr_q <= 2'b00;
        end else begin
            sr_q <= {sr_q[0], sig};
        end
    end

    assign rise = (sr_q == 2'b01);

endmodule

// File: rtl/sdram_arbiter.sv
// Shared SDRAM port scheduler: captures request edges, picks a winner and runs the
// issue / busy / done handshake with the controller.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned STARVE  = 32
) (
    input  logic       clk_sys,
    input  logic       RESET,
    input  logic [3:0] REQ_SIG,
    input  logic [3:0] REQ_EN,
    input  logic       DMA_RUNNING,
    input  logic       sdram_ready,
    output logic [3:0] GRANT,
    output logic       SDRAM_RD_PULSE,
    output logic       SDRAM_WR_PULSE,
    output logic       SDRAM_RD_TYPE,
    output logic [3:0] DONE,
    output logic [3:0] OVERRUN,
    output logic       TIMEOUT_ERR,
    output logic       DMA_SDRAM_BUSY
);

    logic [3:0]       rise;
    logic [3:0]       sel;
    logic [3:0]       take;
    logic             starve;

    arb_state_e       state_q, state_d;
    logic [3:0]       pend_q, pend_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       done_q, done_d;
    logic [3:0]       ovr_q, ovr_d;
    logic             rd_q, rd_d;
    logic             wr_q, wr_d;
    logic             type_q, type_d;
    logic             terr_q, terr_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;

    for (genvar i = 0; i < 4; i++) begin : g_edge
        sdram_arb_edge u_edge (
            .clk_sys (clk_sys),
            .RESET   (RESET),
            .sig     (REQ_SIG[i]),
            .rise    (rise[i])
        );
    end

    assign starve = (32'(age_q) >= STARVE);
    assign sel    = prio_select(pend_q & REQ_EN, DMA_RUNNING, starve);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = 4'b0000;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        type_d  = 1'b0;
        terr_d  = 1'b0;
        tmo_d   = tmo_q;
        take    = 4'b0000;
        unique case (state_q)
            StIdle: begin
                if (sdram_ready && (|sel)) begin
                    take    = sel;
                    grant_d = sel;
                    wr_d    = sel[REQ_CDWR];
                    rd_d    = ~sel[REQ_CDWR];
                    type_d  = sel[REQ_CROM];
                    state_d = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWaitBusy;
            end
            StWaitBusy: begin
                if (!sdram_ready) begin
                    state_d = StWaitDone;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    // Controller never accepted the access; drop it without re-queueing.
                    terr_d  = 1'b1;
                    grant_d = 4'b0000;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StWaitDone: begin
                // GRANT is held through the DONE cycle so downstream latches see the owner.
                if (|done_q) begin
                    grant_d = 4'b0000;
                    state_d = StIdle;
                end else if (sdram_ready) begin
                    done_d = grant_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ovr_d  = rise & REQ_EN & pend_q & ~take;
        pend_d = ((pend_q & ~take) | rise) & REQ_EN;
        age_d  = age_q;
        if (take[REQ_M68K]) begin
            age_d = '0;
        end else if (pend_q[REQ_M68K] && (age_q != '1)) begin
            age_d = age_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            state_q <= StIdle;
            pend_q  <= 4'b0000;
            grant_q <= 4'b0000;
            done_q  <= 4'b0000;
            ovr_q   <= 4'b0000;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            type_q  <= 1'b0;
            terr_q  <= 1'b0;
            age_q   <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            type_q  <= type_d;
            terr_q  <= terr_d;
            age_q   <= age_d;
            tmo_q   <= tmo_d;
        end
    end

    assign GRANT          = grant_q;
    assign DONE           = done_q;
    assign OVERRUN        = ovr_q;
    assign SDRAM_RD_PULSE = rd_q;
    assign SDRAM_WR_PULSE = wr_q;
    assign SDRAM_RD_TYPE  = type_q;
    assign TIMEOUT_ERR    = terr_q;
    assign DMA_SDRAM_BUSY = DMA_RUNNING & (grant_q[REQ_CDWR] | grant_q[REQ_M68K] |
                                           pend_q[REQ_CDWR] | pend_q[REQ_M68K]);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed scenarios plus random traffic, checked every cycle against a behavioural model.
module tb_sdram_arbiter;

    localparam int unsigned TO = 16;
    localparam int unsigned ST = 8;

    logic       clk_sys = 1'b0;
    logic       RESET;
    logic [3:0] REQ_SIG;
    logic [3:0] REQ_EN;
    logic       DMA_RUNNING;
    logic       sdram_ready;
    logic [3:0] GRANT;
    logic [3:0] DONE;
    logic [3:0] OVERRUN;
    logic       SDRAM_RD_PULSE;
    logic       SDRAM_WR_PULSE;
    logic       SDRAM_RD_TYPE;
    logic       TIMEOUT_ERR;
    logic       DMA_SDRAM_BUSY;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: request history, pending set, current access progress.
    bit [3:0] m_l1, m_l2, m_pend;
    int       m_owner, m_wait, m_age;
    bit       m_issue, m_low, m_doneph;
    bit [3:0] e_done, e_ovr;
    bit       e_rd, e_wr, e_type, e_to;

    // Controller emulation.
    int ctl_t, ctl_drop, ctl_busy;
    bit ctl_on, ctl_rand, ctl_low;

    sdram_arbiter #(
        .TIMEOUT (TO),
        .STARVE  (ST)
    ) dut (
        .clk_sys        (clk_sys),
        .RESET          (RESET),
        .REQ_SIG        (REQ_SIG),
        .REQ_EN         (REQ_EN),
        .DMA_RUNNING    (DMA_RUNNING),
        .sdram_ready    (sdram_ready),
        .GRANT          (GRANT),
        .SDRAM_RD_PULSE (SDRAM_RD_PULSE),
        .SDRAM_WR_PULSE (SDRAM_WR_PULSE),
        .SDRAM_RD_TYPE  (SDRAM_RD_TYPE),
        .DONE           (DONE),
        .OVERRUN        (OVERRUN),
        .TIMEOUT_ERR    (TIMEOUT_ERR),
        .DMA_SDRAM_BUSY (DMA_SDRAM_BUSY)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, want);
        end
    endtask

    function automatic int pick(input bit [3:0] p, input bit dma, input bit starve);
        int ord [4];
        int r;
        r = -1;
        if (dma) ord = '{1, 2, 0, 3};
        else     ord = '{0, 1, 2, 3};
        if (starve && p[3]) r = 3;
        for (int k = 0; k < 4; k++) begin
            if (r < 0 && p[ord[k]]) r = ord[k];
        end
        return r;
    endfunction

    task automatic model_reset();
        m_l1 = '0; m_l2 = '0; m_pend = '0;
        m_owner = -1; m_wait = 0; m_age = 0;
        m_issue = 0; m_low = 0; m_doneph = 0;
        e_done = '0; e_ovr = '0; e_rd = 0; e_wr = 0; e_type = 0; e_to = 0;
        ctl_on = 0; ctl_t = 0; ctl_low = 0;
    endtask

    task automatic model_step();
        bit [3:0] rise, pold;
        int w;
        rise = REQ_EN & m_l1 & ~m_l2;
        m_l2 = m_l1;
        m_l1 = REQ_SIG;
        pold = m_pend;
        e_done = '0; e_ovr = '0; e_rd = 0; e_wr = 0; e_type = 0; e_to = 0;
        w = -1;
        if (m_owner < 0) begin
            if (sdram_ready) w = pick(pold & REQ_EN, DMA_RUNNING, m_age >= ST);
            if (w >= 0) begin
                m_owner = w; m_issue = 1; m_low = 0; m_doneph = 0; m_wait = 0;
                if (w == 0) e_wr = 1;
                else begin e_rd = 1; e_type = (w == 1); end
            end
        end else if (m_doneph) begin
            m_owner = -1;
        end else if (m_issue) begin
            m_issue = 0;
            m_wait = 0;
        end else if (!m_low) begin
            if (!sdram_ready) m_low = 1;
            else begin
                m_wait++;
                if (m_wait == TO) begin e_to = 1; m_owner = -1; end
            end
        end else if (sdram_ready) begin
            e_done[m_owner] = 1;
            m_doneph = 1;
        end
        for (int i = 0; i < 4; i++) begin
            if (w == i) m_pend[i] = 0;
            e_ovr[i] = rise[i] & pold[i] & (w != i);
            if (rise[i]) m_pend[i] = 1;
            if (!REQ_EN[i]) m_pend[i] = 0;
        end
        if (w == 3) m_age = 0;
        else if (pold[3] && m_age < 255) m_age++;
    endtask

    task automatic compare_all();
        logic [3:0] g;
        g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        chk("grant", GRANT, g);
        chk("done", DONE, e_done);
        chk("overrun", OVERRUN, e_ovr);
        chk("rd_pulse", 4'(SDRAM_RD_PULSE), 4'(e_rd));
        chk("wr_pulse", 4'(SDRAM_WR_PULSE), 4'(e_wr));
        chk("rd_type", 4'(SDRAM_RD_TYPE), 4'(e_type));
        chk("timeout_err", 4'(TIMEOUT_ERR), 4'(e_to));
        chk("dma_busy", 4'(DMA_SDRAM_BUSY),
            4'(DMA_RUNNING & (g[0] | g[3] | m_pend[0] | m_pend[3])));
    endtask

    task automatic drive_ctl();
        if (e_rd || e_wr) begin
            ctl_on = 1;
            ctl_t = 0;
            if (ctl_rand) begin
                ctl_drop = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 3));
                ctl_busy = int'($urandom_range(1, 6));
            end
        end else if (ctl_on) begin
            ctl_t++;
        end
        if (ctl_low) sdram_ready = 1'b0;
        else if (ctl_on && ctl_drop != 0 && ctl_t >= ctl_drop && ctl_t < ctl_drop + ctl_busy)
            sdram_ready = 1'b0;
        else sdram_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        model_step();
        #1;
        compare_all();
        drive_ctl();
    endtask

    task automatic until_done(input string tag, input logic [3:0] mask);
        int n = 0;
        while ((DONE & mask) == 4'b0000 && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 4'(n < 100), 4'b0001);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"}, GRANT, 4'b0000);
        chk({tag, "_done"}, DONE, 4'b0000);
        chk({tag, "_ovr"}, OVERRUN, 4'b0000);
        chk({tag, "_pulses"}, {SDRAM_RD_PULSE, SDRAM_WR_PULSE, SDRAM_RD_TYPE, TIMEOUT_ERR},
            4'b0000);
        chk({tag, "_busy"}, 4'(DMA_SDRAM_BUSY), 4'b0000);
    endtask

    initial begin
        logic [3:0] seen;
        bit got;
        RESET = 1'b1;
        REQ_SIG = 4'b0000;
        REQ_EN = 4'b1111;
        DMA_RUNNING = 1'b0;
        sdram_ready = 1'b1;
        ctl_rand = 0; ctl_drop = 2; ctl_busy = 5;
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1;
        chk_zero("reset");
        RESET = 1'b0;
        repeat (3) tick();

        // Single M68K read: pulse two edges after the first sampled edge.
        REQ_SIG[3] = 1'b1;
        tick(); tick();
        chk("m68k_early", 4'(SDRAM_RD_PULSE), 4'b0000);
        tick();
        chk("m68k_pulse", 4'(SDRAM_RD_PULSE), 4'b0001);
        chk("m68k_grant", GRANT, 4'b1000);
        chk("m68k_type", 4'(SDRAM_RD_TYPE), 4'b0000);
        repeat (7) tick();
        chk("m68k_not_done", DONE, 4'b0000);
        tick();
        chk("m68k_done", DONE, 4'b1000);
        chk("m68k_grant_held", GRANT, 4'b1000);
        tick();
        chk("m68k_release", GRANT, 4'b0000);
        REQ_SIG = 4'b0000;
        repeat (2) tick();

        // CROM and M68K together, normal order.
        REQ_SIG = 4'b1010;
        repeat (3) tick();
        chk("crom_first", GRANT, 4'b0010);
        chk("crom_burst", 4'(SDRAM_RD_TYPE), 4'b0001);
        until_done("crom_done", 4'b0010);
        tick();
        chk("gap_idle", GRANT, 4'b0000);
        tick();
        chk("m68k_second", GRANT, 4'b1000);
        chk("m68k_second_pulse", 4'(SDRAM_RD_PULSE), 4'b0001);
        until_done("m68k2_done", 4'b1000);
        REQ_SIG = 4'b0000;
        repeat (2) tick();

        // DMA order: SROM ahead of CDWR.
        DMA_RUNNING = 1'b1;
        REQ_SIG = 4'b0101;
        repeat (3) tick();
        chk("dma_srom", GRANT, 4'b0100);
        chk("dma_busy_pend", 4'(DMA_SDRAM_BUSY), 4'b0001);
        until_done("srom_done", 4'b0100);
        repeat (2) tick();
        chk("cdwr_wr", 4'(SDRAM_WR_PULSE), 4'b0001);
        chk("cdwr_grant", GRANT, 4'b0001);
        until_done("cdwr_done", 4'b0001);
        chk("dma_busy_done", 4'(DMA_SDRAM_BUSY), 4'b0001);
        tick();
        chk("dma_busy_clear", 4'(DMA_SDRAM_BUSY), 4'b0000);
        REQ_SIG = 4'b0000;
        repeat (2) tick();

        // Starvation: CROM/SROM keep re-requesting while M68K waits.
        ctl_drop = 1; ctl_busy = 1;
        got = 0;
        for (int c = 0; c < 300 && !got; c++) begin
            REQ_SIG[1] = ((c % 4) < 2);
            REQ_SIG[2] = (((c + 2) % 4) < 2);
            if (c == 3) REQ_SIG[3] = 1'b1;
            tick();
            if (GRANT[3]) got = 1;
        end
        chk("starve_grant", 4'(got), 4'b0001);
        REQ_SIG = 4'b0000;
        until_done("starve_done", 4'b1000);
        repeat (40) tick();

        // Timeout: ready never drops after the pulse.
        DMA_RUNNING = 1'b0;
        ctl_drop = 0;
        REQ_SIG = 4'b1000;
        repeat (3) tick();
        chk("to_pulse", 4'(SDRAM_RD_PULSE), 4'b0001);
        repeat (16) tick();
        chk("to_wait_grant", GRANT, 4'b1000);
        chk("to_wait_err", 4'(TIMEOUT_ERR), 4'b0000);
        tick();
        chk("to_err", 4'(TIMEOUT_ERR), 4'b0001);
        chk("to_grant", GRANT, 4'b0000);

        // Second edge while pending, controller held busy.
        ctl_low = 1; sdram_ready = 1'b0;
        REQ_SIG[3] = 1'b0; tick(); tick();
        REQ_SIG[3] = 1'b1; tick(); tick();
        REQ_SIG[3] = 1'b0; tick(); tick();
        REQ_SIG[3] = 1'b1; tick(); tick();
        chk("overrun", OVERRUN, 4'b1000);
        ctl_low = 0; sdram_ready = 1'b1;
        ctl_drop = 2; ctl_busy = 3;
        until_done("ovr_served", 4'b1000);
        REQ_SIG = 4'b0000;
        repeat (3) tick();

        // Reset in WAIT_DONE abandons the access.
        ctl_drop = 1; ctl_busy = 10;
        REQ_SIG = 4'b0010;
        repeat (3) tick();
        chk("rst_issue", GRANT, 4'b0010);
        repeat (3) tick();
        REQ_SIG = 4'b0000;
        #2;
        RESET = 1'b1;
        #1;
        chk_zero("midrst");
        @(posedge clk_sys);
        #1;
        RESET = 1'b0;
        model_reset();
        sdram_ready = 1'b1;
        seen = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            tick();
            seen = seen | DONE;
        end
        chk("no_done_after_rst", seen, 4'b0000);

        // Random traffic.
        ctl_rand = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) REQ_SIG[i] = ~REQ_SIG[i];
            end
            if ($urandom_range(0, 63) == 0) DMA_RUNNING = ~DMA_RUNNING;
            if ($urandom_range(0, 99) == 0)
                REQ_EN = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
